// File: rtl/sd_cmd_ctrl.sv
// Host-side SD CMD line sequencer: serializes a 48-bit command token with CRC7,
// then optionally captures and checks an R48 or R136 response from the card.
module sd_cmd_ctrl #(
  parameter int gNcrMax = 64,
  parameter int gNccMin = 8
) (
  input  logic         Clk,
  input  logic         nResetAsync,
  input  logic         iStrobe,
  input  logic         iStart,
  input  logic [5:0]   iIndex,
  input  logic [31:0]  iArg,
  input  logic [1:0]   iRespType,
  output logic         oBusy,
  output logic         oDone,
  output logic [3:0]   oStatus,
  output logic [5:0]   oRespIndex,
  output logic [31:0]  oRespArg,
  output logic [127:0] oResp136,
  output logic         oCmd,
  output logic         oCmdEn,
  input  logic         iCmd
);

  localparam int MAX_A   = (gNcrMax > 135) ? gNcrMax : 135;
  localparam int CNT_MAX = (gNccMin > MAX_A) ? gNccMin : MAX_A;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    RECV,
    NCC_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [39:0]        tx;
  logic [6:0]         crc;
  logic [5:0]         idx_q;
  logic [1:0]         type_q;
  logic [126:0]       rx;
  logic [127:0]       rx_new;
  logic [CNT_W-1:0]   rx_last;
  logic               tx_bit;
  logic               send_done;
  logic               wait_timeout;
  logic               rx_done;
  logic               ncc_done;
  logic [3:0]         resp_status;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  always_comb begin
    rx_new       = {rx, iCmd};
    rx_last      = (type_q == 2'b11) ? CNT_W'(134) : CNT_W'(46);
    send_done    = (state_q == SEND) && iStrobe && (cnt == CNT_W'(48));
    wait_timeout = (state_q == WAIT_RESP) && iStrobe && iCmd && (cnt == CNT_W'(gNcrMax - 1));
    rx_done      = (state_q == RECV) && iStrobe && (cnt == rx_last);
    ncc_done     = (state_q == NCC_WAIT) && iStrobe && (cnt == CNT_W'(gNccMin - 1));

    // Token layout: 40 payload bits, then the CRC7 remainder, then the end bit
    tx_bit = 1'b1;
    if (cnt < CNT_W'(40)) begin
      tx_bit = tx[39];
    end else if (cnt < CNT_W'(47)) begin
      tx_bit = crc[6];
    end

    // CRC and index are only meaningful for the checked R48 type
    resp_status    = 4'b0000;
    resp_status[1] = ~rx_new[0];
    if (type_q == 2'b01) begin
      resp_status[2] = (crc != rx_new[7:1]);
      resp_status[0] = (rx_new[45:40] != idx_q);
    end
  end

  always_ff @(posedge Clk or negedge nResetAsync) begin
    if (!nResetAsync) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (send_done) begin
          state_d = (type_q == 2'b00) ? NCC_WAIT : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (iStrobe && !iCmd) begin
          state_d = RECV;
        end else if (wait_timeout) begin
          state_d = NCC_WAIT;
        end
      end
      RECV: begin
        if (rx_done) begin
          state_d = NCC_WAIT;
        end
      end
      NCC_WAIT: begin
        if (ncc_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nResetAsync) begin
    if (!nResetAsync) begin
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oStatus    <= '0;
      oRespIndex <= '0;
      oRespArg   <= '0;
      oResp136   <= '0;
      oCmd       <= 1'b1;
      oCmdEn     <= 1'b1;
      cnt        <= '0;
      tx         <= '0;
      crc        <= '0;
      idx_q      <= '0;
      type_q     <= '0;
      rx         <= '0;
    end else begin
      oDone <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            idx_q   <= iIndex;
            type_q  <= iRespType;
            tx      <= {2'b01, iIndex, iArg};
            crc     <= '0;
            cnt     <= '0;
            oBusy   <= 1'b1;
            oStatus <= '0;
          end
        end
        SEND: begin
          if (send_done) begin
            cnt <= '0;
            if (type_q == 2'b00) begin
              oDone <= 1'b1;
            end else begin
              oCmdEn <= 1'b0;
            end
          end else if (iStrobe) begin
            oCmd <= tx_bit;
            cnt  <= cnt + 1'b1;
            if (cnt < CNT_W'(40)) begin
              tx  <= {tx[38:0], 1'b0};
              crc <= crc7_step(crc, tx[39]);
            end else if (cnt < CNT_W'(47)) begin
              crc <= {crc[5:0], 1'b0};
            end
          end
        end
        WAIT_RESP: begin
          if (iStrobe) begin
            if (!iCmd) begin
              cnt <= '0;
              crc <= '0;
            end else if (wait_timeout) begin
              cnt     <= '0;
              oStatus <= 4'b1000;
              oDone   <= 1'b1;
              oCmdEn  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (iStrobe) begin
            rx  <= rx_new[126:0];
            cnt <= cnt + 1'b1;
            // The R48 CRC covers frame bits 46:8, the first 39 bits after the start bit
            if (cnt < CNT_W'(39)) begin
              crc <= crc7_step(crc, iCmd);
            end
            if (rx_done) begin
              cnt     <= '0;
              oDone   <= 1'b1;
              oCmdEn  <= 1'b1;
              oStatus <= resp_status;
              if (type_q == 2'b11) begin
                oResp136 <= rx_new;
              end else begin
                oRespIndex <= rx_new[45:40];
                oRespArg   <= rx_new[39:8];
              end
            end
          end
        end
        NCC_WAIT: begin
          if (ncc_done) begin
            cnt   <= '0;
            oBusy <= 1'b0;
          end else if (iStrobe) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: a card model answers commands, and a scoreboard
// of expected tokens/status/responses is compared on every completion pulse.
module tb_sd_cmd_ctrl;

  logic         clk;
  logic         rst_n;
  logic         strobe;
  logic         start;
  logic [5:0]   index;
  logic [31:0]  arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [3:0]   status;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [127:0] resp136;
  logic         cmd_out;
  logic         cmd_en;
  logic         cmd_in;

  sd_cmd_ctrl #(.gNcrMax(64), .gNccMin(8)) dut (
    .Clk(clk),
    .nResetAsync(rst_n),
    .iStrobe(strobe),
    .iStart(start),
    .iIndex(index),
    .iArg(arg),
    .iRespType(resp_type),
    .oBusy(busy),
    .oDone(done),
    .oStatus(status),
    .oRespIndex(resp_index),
    .oRespArg(resp_arg),
    .oResp136(resp136),
    .oCmd(cmd_out),
    .oCmdEn(cmd_en),
    .iCmd(cmd_in)
  );

  typedef struct {
    string        tag;
    logic [47:0]  token;
    logic [3:0]   status;
    logic [5:0]   ridx;
    logic [31:0]  rarg;
    logic [127:0] r136;
  } exp_t;

  exp_t         sb[$];
  int           passed = 0;
  int           failed = 0;
  int           total = 0;
  int           strobe_div = 1;
  int           phase = 0;
  logic [47:0]  captured;
  logic [5:0]   m_idx;
  logic [31:0]  m_arg;
  logic [127:0] m_r136;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe changes only on the falling edge so it is stable at every rising edge
  initial begin
    strobe = 1'b0;
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % strobe_div;
      strobe = (phase == 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_token(input logic [5:0] idx, input logic [31:0] a);
    return {2'b01, idx, a, crc7({2'b01, idx, a}), 1'b1};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitStrobe();
    int g;
    g = 0;
    @(posedge clk);
    while (!strobe && g < 64) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  // Counts strobes until the completion pulse; -1 means it never came
  task automatic waitDone(output int n);
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      if (strobe) n++;
      #1;
      if (done === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic pushExpect(input string tag, input logic [47:0] tok, input logic [3:0] st,
                            input logic [1:0] typ, input logic [135:0] frame);
    exp_t e;
    if (!st[3]) begin
      if (typ == 2'b01 || typ == 2'b10) begin
        m_idx = frame[45:40];
        m_arg = frame[39:8];
      end else if (typ == 2'b11) begin
        m_r136 = frame[127:0];
      end
    end
    e.tag    = tag;
    e.token  = tok;
    e.status = st;
    e.ridx   = m_idx;
    e.rarg   = m_arg;
    e.r136   = m_r136;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] a, input logic [1:0] typ);
    index     = idx;
    arg       = a;
    resp_type = typ;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    index     = 6'h2A;
    arg       = 32'hDEADBEEF;
    resp_type = 2'b00;
    checkOutput("busy_after_accept", busy, 1);
    for (int i = 47; i >= 0; i--) begin
      waitStrobe();
      captured[i] = cmd_out;
    end
  endtask

  task automatic cardReply(input int delay, input logic [135:0] frame, input int len, input bit poke);
    for (int d = 0; d < delay; d++) waitStrobe();
    for (int i = len - 1; i >= 1; i--) begin
      cmd_in = frame[i];
      if (poke && i == 70) begin
        start     = 1'b1;
        index     = 6'h11;
        resp_type = 2'b00;
      end
      waitStrobe();
      start = 1'b0;
    end
    cmd_in = frame[0];
  endtask

  task automatic finishCmd();
    exp_t e;
    int   n;
    int   line_bad;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, "_token"}, captured, e.token);
    checkOutput({e.tag, "_status"}, status, e.status);
    checkOutput({e.tag, "_resp_index"}, resp_index, e.ridx);
    checkOutput({e.tag, "_resp_arg"}, resp_arg, e.rarg);
    checkOutput({e.tag, "_resp136"}, resp136, e.r136);
    n = 0;
    line_bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (strobe) n++;
      #1;
      if (cmd_out !== 1'b1 || cmd_en !== 1'b1) line_bad++;
      if (busy === 1'b0) break;
    end
    checkOutput({e.tag, "_ncc_strobes"}, n, 8);
    checkOutput({e.tag, "_ncc_line_high"}, line_bad, 0);
  endtask

  task automatic runResp(input string tag, input logic [5:0] idx, input logic [31:0] a,
                         input logic [1:0] typ, input logic [47:0] tok, input logic [135:0] frame,
                         input int len, input logic [3:0] st, input int delay, input bit poke);
    int n;
    pushExpect(tag, tok, st, typ, frame);
    applyStimulus(idx, a, typ);
    waitStrobe();
    checkOutput({tag, "_released"}, cmd_en, 0);
    cardReply(delay, frame, len, poke);
    waitDone(n);
    cmd_in = 1'b1;
    checkOutput({tag, "_done_latency"}, n, 1);
    finishCmd();
  endtask

  initial begin
    int           n;
    int           nb;
    int           bad;
    int           done_seen;
    logic         s;
    logic         prev;
    logic [47:0]  pre;
    logic [47:0]  tok;
    logic [47:0]  idx_err_frame;
    logic [127:0] cid;

    rst_n     = 1'b0;
    start     = 1'b0;
    index     = '0;
    arg       = '0;
    resp_type = '0;
    cmd_in    = 1'b1;
    m_idx     = '0;
    m_arg     = '0;
    m_r136    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_status", status, 0);
    checkOutput("reset_resp_index", resp_index, 0);
    checkOutput("reset_resp_arg", resp_arg, 0);
    checkOutput("reset_resp136", resp136, 0);
    checkOutput("reset_cmd", cmd_out, 1);
    checkOutput("reset_cmd_en", cmd_en, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] CMD0, no response");
    pushExpect("cmd0", 48'h400000000095, 4'b0000, 2'b00, '0);
    applyStimulus(6'd0, 32'h0, 2'b00);
    waitDone(n);
    checkOutput("cmd0_done_latency", n, 1);
    finishCmd();

    $display("[TB] CMD8 with R48 responses");
    runResp("cmd8_ok", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, 136'h08000001AA13, 48, 4'b0000, 5, 1'b0);
    runResp("cmd8_crc", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, 136'h08000001AA15, 48, 4'b0100, 3, 1'b0);
    idx_err_frame = {2'b00, 6'h09, 32'h000001AA, crc7({2'b00, 6'h09, 32'h000001AA}), 1'b1};
    runResp("cmd8_index", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, {88'h0, idx_err_frame}, 48, 4'b0001, 2, 1'b0);
    runResp("cmd8_end", 6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, 136'h08000001AA12, 48, 4'b0010, 7, 1'b0);

    $display("[TB] ACMD41 with unchecked R3");
    runResp("acmd41_r3", 6'd41, 32'h40FF8000, 2'b10, make_token(6'd41, 32'h40FF8000),
            136'h3F00FF8000FF, 48, 4'b0000, 4, 1'b0);

    $display("[TB] response timeout");
    pushExpect("cmd8_timeout", 48'h48000001AA87, 4'b1000, 2'b01, '0);
    applyStimulus(6'd8, 32'h1AA, 2'b01);
    waitStrobe();
    checkOutput("timeout_released", cmd_en, 0);
    waitDone(n);
    checkOutput("timeout_strobes", n, 64);
    checkOutput("timeout_cmd_en", cmd_en, 1);
    finishCmd();

    $display("[TB] CMD2 with R136 and an ignored second start");
    cid = 128'h0353445344303030_10A1B2C3D400E1A1;
    runResp("cmd2_r136", 6'd2, 32'h0, 2'b11, 48'h42000000004D, {8'h3F, cid}, 136, 4'b0000, 6, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ignored_start_idle", busy, 0);

    $display("[TB] slow strobe with reset mid-send");
    strobe_div = 4;
    @(posedge clk);
    #1;
    index     = 6'd17;
    arg       = 32'h12345678;
    resp_type = 2'b01;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev  = cmd_out;
    nb    = 0;
    bad   = 0;
    pre   = '0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      s = strobe;
      #1;
      if (!s && cmd_out !== prev) bad++;
      if (s) begin
        pre = {pre[46:0], cmd_out};
        nb++;
      end
      prev = cmd_out;
    end
    tok = make_token(6'd17, 32'h12345678);
    checkOutput("slow_bit_count", nb, 15);
    checkOutput("slow_off_strobe_changes", bad, 0);
    checkOutput("slow_prefix", pre[14:0], tok[47:33]);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_cmd", cmd_out, 1);
    checkOutput("midreset_cmd_en", cmd_en, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_status", status, 0);
    checkOutput("midreset_resp_index", resp_index, 0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    checkOutput("midreset_no_done", done_seen, 0);
    checkOutput("midreset_idle", busy, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
